// File: rtl/pmt_timebin_pkg.sv
// -----------------------------------------------------------------------------
// pmt_timebin_pkg
// Shared definitions for the timebin-count UART transmitter:
//   - calc_clks_per_bit() : rounded clock-cycles-per-UART-bit
//   - TX FSM state encodings (IDLE, START, DATA, STOP)
//   - 8N1 frame constants
//   - DROP_MAX            : saturation value of the dropped-bin counter
// -----------------------------------------------------------------------------
package pmt_timebin_pkg;

  // Round-to-nearest so that, for example, 50 MHz / 115200 baud gives 434.
  function automatic int calc_clks_per_bit(input longint clk_hz, input longint baud);
    return int'((clk_hz + (baud / 2)) / baud);
  endfunction

  // TX FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // 8N1 frame layout
  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/pmt_byte_fifo.sv
// -----------------------------------------------------------------------------
// pmt_byte_fifo
// Single-clock synchronous byte FIFO, depth 2^FIFO_AW. The head entry is
// always visible on rd_data; rd_en consumes it. A write while full is only
// accepted when a read happens in the same cycle.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   wr_en, wr_data    : push request and data
//   rd_en, rd_data    : pop request and head-of-queue data
//   level             : occupancy 0..2^FIFO_AW
//   full, empty       : occupancy flags
// -----------------------------------------------------------------------------
module pmt_byte_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic [FIFO_AW:0]   level,
  output logic               full,
  output logic               empty
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LEVEL_MAX = {1'b1, {FIFO_AW{1'b0}}};

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;

  logic w_rd;
  logic w_wr;

  assign full    = (r_level == LEVEL_MAX);
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];

  assign w_rd = rd_en & ~empty;
  assign w_wr = wr_en & (~full | w_rd);

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are valid, and leaving the array unreset lets it map onto plain
  // registers or distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/timebin_count_uart_tx.sv
// -----------------------------------------------------------------------------
// timebin_count_uart_tx
// Captures 8-bit PMT timebin counts on the trigger's bin strobe, buffers them
// in a FIFO and sends them LSB first as 8N1 UART frames. Bins arriving while
// the FIFO is full are dropped, flagged in a sticky overflow bit and counted.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bin_strobe   : one-cycle bin-end pulse
//   bin_count    : count to capture when bin_strobe is high
//   enable       : accept bins when 1 (FIFO keeps draining when 0)
//   clear_ovf    : synchronous clear of overflow and drop_count
//   tx           : UART line, idle high, registered
//   busy         : frame on the line or data buffered
//   fifo_level   : FIFO occupancy
//   overflow     : sticky dropped-bin flag
//   drop_count   : saturating dropped-bin count
// -----------------------------------------------------------------------------
module timebin_count_uart_tx
  import pmt_timebin_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bin_strobe,
  input  logic [7:0]       bin_count,
  input  logic             enable,
  input  logic             clear_ovf,
  output logic             tx,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_level,
  output logic             overflow,
  output logic [15:0]      drop_count
);

  localparam int                CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam int                BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT     = 3'(DATA_BITS - 1);

  logic [1:0]        r_state;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_overflow;
  logic [15:0]       r_drop_count;

  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [7:0] w_fifo_head;
  logic       w_baud_done;
  logic       w_pop;
  logic       w_push_req;
  logic       w_drop;
  logic       w_push;

  assign w_baud_done = (r_baud_cnt == BAUD_LAST);

  // Pops happen only from IDLE or at the end of a stop bit, and only when
  // data is present, so a push never falls through an empty FIFO.
  assign w_pop = ~w_fifo_empty &
                 ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_baud_done));

  assign w_push_req = bin_strobe & enable;
  assign w_drop     = w_push_req & w_fifo_full & ~w_pop;
  assign w_push     = w_push_req & ~w_drop;

  pmt_byte_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_push),
    .wr_data (bin_count),
    .rd_en   (w_pop),
    .rd_data (w_fifo_head),
    .level   (fifo_level),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  // UART transmit FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift    <= w_fifo_head;
            r_tx       <= 1'b0;
            r_baud_cnt <= '0;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_tx       <= r_shift[0];
            r_bit_idx  <= '0;
            r_state    <= ST_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == LAST_BIT) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            // Back-to-back frames: go straight to the next start bit.
            if (w_pop) begin
              r_shift <= w_fifo_head;
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // Overflow accounting; a drop in the same cycle as clear_ovf wins, so the
  // dropped bin is never lost from the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_ovf)                    r_drop_count <= 16'd1;
      else if (r_drop_count != DROP_MAX) r_drop_count <= r_drop_count + 1'b1;
    end else if (clear_ovf) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign tx         = r_tx;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign busy       = (r_state != ST_IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_timebin_count_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_timebin_count_uart_tx
// Directed bench at CLK_HZ=50 MHz, BAUD=5 Mbaud (10 clocks per bit). A passive
// UART receiver collects the bytes seen on tx for comparison against
// hand-written expected sequences.
// -----------------------------------------------------------------------------
module tb_timebin_count_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        bin_strobe;
  logic [7:0]  bin_count;
  logic        enable;
  logic        clear_ovf;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];

  timebin_count_uart_tx #(
    .CLK_HZ  (50000000),
    .BAUD    (5000000),
    .FIFO_AW (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bin_strobe (bin_strobe),
    .bin_count  (bin_count),
    .enable     (enable),
    .clear_ovf  (clear_ovf),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Passive 8N1 receiver sampling mid-bit (10 clocks per bit).
  always begin : uart_rx
    logic [7:0] b;
    logic       start_ok;
    @(negedge tx);
    repeat (5) @(posedge clk);
    #1;
    start_ok = (tx == 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(posedge clk);
      #1;
      b[i] = tx;
    end
    repeat (10) @(posedge clk);
    #1;
    if (start_ok && tx) rx_q.push_back(b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] v;

    reset      = 1'b1;
    bin_strobe = 1'b0;
    bin_count  = 8'h00;
    enable     = 1'b1;
    clear_ovf  = 1'b0;
    #1;
    check("rst_tx",    {31'd0, tx},        32'd1);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_level", {27'd0, fifo_level}, 32'd0);
    check("rst_ovf",   {31'd0, overflow},  32'd0);
    check("rst_drop",  {16'd0, drop_count}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();

    // ---- Single bin 0xA5 ----
    v          = 8'hA5;
    bin_count  = v;
    bin_strobe = 1'b1;
    tick();
    bin_strobe = 1'b0;
    check("single_level1", {27'd0, fifo_level}, 32'd1);
    check("single_tx_idle", {31'd0, tx}, 32'd1);
    tick();                                    // t=0: pop, start bit
    check("single_start0", {31'd0, tx}, 32'd0);
    check("single_level0", {27'd0, fifo_level}, 32'd0);
    check("single_busy",   {31'd0, busy}, 32'd1);
    repeat (9) tick();                         // t=9
    check("single_start9", {31'd0, tx}, 32'd0);
    tick();                                    // t=10: bit0
    check("single_bit0", {31'd0, tx}, {31'd0, v[0]});
    for (int k = 1; k < 8; k++) begin
      repeat (10) tick();
      check($sformatf("single_bit%0d", k), {31'd0, tx}, {31'd0, v[k]});
    end
    repeat (10) tick();                        // t=90: stop
    check("single_stop", {31'd0, tx}, 32'd1);
    repeat (9) tick();                         // t=99
    check("single_busy99", {31'd0, busy}, 32'd1);
    tick();                                    // t=100
    check("single_busy100", {31'd0, busy}, 32'd0);
    check("single_rx_n", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("single_rx_byte", {24'd0, rx_q[0]}, 32'hA5);
    rx_q.delete();

    // ---- Burst of 20 consecutive strobes (counts 0..19) ----
    bin_strobe = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bin_count = 8'(i);
      tick();
    end
    bin_strobe = 1'b0;
    check("burst_level", {27'd0, fifo_level}, 32'd16);
    check("burst_ovf",   {31'd0, overflow},  32'd1);
    check("burst_drop",  {16'd0, drop_count}, 32'd3);

    // clear_ovf alone
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clr_ovf",  {31'd0, overflow},  32'd0);
    check("clr_drop", {16'd0, drop_count}, 32'd0);

    // clear_ovf coincident with a drop (FIFO still full, no pop this cycle)
    clear_ovf  = 1'b1;
    bin_strobe = 1'b1;
    bin_count  = 8'hEE;
    tick();
    clear_ovf  = 1'b0;
    bin_strobe = 1'b0;
    check("clr_drop_ovf",  {31'd0, overflow},  32'd1);
    check("clr_drop_cnt",  {16'd0, drop_count}, 32'd1);

    // Strobe exactly on the STOP->START pop of frame 0 (edge 102)
    repeat (79) tick();
    check("fullpop_pre_level", {27'd0, fifo_level}, 32'd16);
    check("fullpop_pre_tx",    {31'd0, tx}, 32'd1);
    bin_strobe = 1'b1;
    bin_count  = 8'h77;
    tick();
    bin_strobe = 1'b0;
    check("fullpop_level", {27'd0, fifo_level}, 32'd16);
    check("fullpop_drop",  {16'd0, drop_count}, 32'd1);
    check("fullpop_tx",    {31'd0, tx}, 32'd0);

    wait_idle(2500, "burst_drain_timeout");
    check("burst_rx_n", rx_q.size(), 32'd18);
    for (int i = 0; i < 18; i++) begin
      logic [7:0] e;
      e = (i < 17) ? 8'(i) : 8'h77;
      if (i < rx_q.size()) check($sformatf("burst_rx%0d", i), {24'd0, rx_q[i]}, {24'd0, e});
    end
    rx_q.delete();

    // ---- enable=0: strobes ignored ----
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    enable    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bin_strobe = 1'b1;
      bin_count  = 8'(8'h40 + i);
      tick();
    end
    bin_strobe = 1'b0;
    check("dis_level", {27'd0, fifo_level}, 32'd0);
    check("dis_tx",    {31'd0, tx}, 32'd1);
    check("dis_drop",  {16'd0, drop_count}, 32'd0);
    check("dis_busy",  {31'd0, busy}, 32'd0);

    // enable dropped mid-frame: frame in flight completes
    enable     = 1'b1;
    bin_strobe = 1'b1;
    bin_count  = 8'h3C;
    tick();
    bin_strobe = 1'b0;
    repeat (30) tick();
    enable     = 1'b0;
    bin_strobe = 1'b1;
    bin_count  = 8'hFF;
    tick();
    bin_strobe = 1'b0;
    check("midoff_level", {27'd0, fifo_level}, 32'd0);
    wait_idle(200, "midoff_timeout");
    check("midoff_rx_n", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("midoff_rx_byte", {24'd0, rx_q[0]}, 32'h3C);
    rx_q.delete();
    enable = 1'b1;

    // ---- Reset during DATA bit 3 of 0x52 (bit3 = 0), with one byte queued ----
    bin_strobe = 1'b1;
    bin_count  = 8'h52;
    tick();
    bin_count  = 8'h11;
    tick();                                    // t=0 of 0x52 frame, 0x11 queued
    bin_strobe = 1'b0;
    repeat (45) tick();                        // t=45, inside bit3
    check("rstmid_pre_tx",    {31'd0, tx}, 32'd0);
    check("rstmid_pre_level", {27'd0, fifo_level}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_tx",    {31'd0, tx}, 32'd1);
    check("rstmid_level", {27'd0, fifo_level}, 32'd0);
    check("rstmid_busy",  {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (120) tick();
    rx_q.delete();
    bin_strobe = 1'b1;
    bin_count  = 8'h96;
    tick();
    bin_strobe = 1'b0;
    wait_idle(200, "rstmid_timeout");
    check("rstmid_rx_n", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("rstmid_rx_byte", {24'd0, rx_q[0]}, 32'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
